// File: rtl/multi_entry_sequencer.sv
// Multi-interface request sequencer: arbitrates eligible entry requests, runs the
// winner's feature as a timed walking-LED sequence and shows its mode on a 7-seg digit.
module multi_entry_sequencer #(
  parameter int unsigned N_IF     = 2,
  parameter int unsigned CODE_W   = 3,
  parameter int unsigned FEAT_W   = 3,
  parameter int unsigned TICK_DIV = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_IF-1:0]            req,
  input  logic [N_IF*CODE_W-1:0]     mode,
  input  logic [N_IF*FEAT_W-1:0]     feat,
  input  logic                       rr_en,
  input  logic                       abort,
  output logic [N_IF-1:0]            grant,
  output logic                       busy,
  output logic                       conflict,
  output logic                       done,
  output logic [(1 << FEAT_W)-2:0]   led,
  output logic [6:0]                 seg
);

  localparam int unsigned IDX_W  = (N_IF > 1) ? $clog2(N_IF) : 1;
  localparam int unsigned LED_W  = (1 << FEAT_W) - 1;
  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_IF - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;

  logic [N_IF-1:0]     elig;
  logic                any_elig;
  logic                conflict_d;
  logic                req_held;

  logic [IDX_W-1:0]    arb_base;
  logic [IDX_W-1:0]    arb_cand;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_found;
  logic [CODE_W-1:0]   arb_mode;
  logic [FEAT_W-1:0]   arb_feat;

  logic [IDX_W-1:0]    win_q, win_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [FEAT_W-1:0]   feat_q, feat_d;
  logic [FEAT_W-1:0]   step_q, step_d;
  logic [TICK_W-1:0]   tick_q, tick_d;

  logic [N_IF-1:0]     grant_d;
  logic                busy_d;
  logic                done_d;
  logic [LED_W-1:0]    led_d;
  logic [6:0]          seg_d;

  function automatic logic [6:0] digit(input logic [2:0] c);
    logic [6:0] s;
    case (c)
      3'd0:    s = 7'h3F;
      3'd1:    s = 7'h06;
      3'd2:    s = 7'h5B;
      3'd3:    s = 7'h4F;
      3'd4:    s = 7'h66;
      3'd5:    s = 7'h6D;
      3'd6:    s = 7'h7D;
      default: s = 7'h07;
    endcase
    return s;
  endfunction

  // Eligibility per interface and pairwise feature-code clash among eligible ones
  always_comb begin
    elig       = '0;
    conflict_d = 1'b0;
    for (int i = 0; i < int'(N_IF); i++) begin
      elig[i] = req[i] && (mode[i*CODE_W +: CODE_W] != '0) &&
                (feat[i*FEAT_W +: FEAT_W] != '0);
    end
    for (int i = 0; i < int'(N_IF); i++) begin
      for (int j = i + 1; j < int'(N_IF); j++) begin
        if (elig[i] && elig[j] &&
            (feat[i*FEAT_W +: FEAT_W] == feat[j*FEAT_W +: FEAT_W])) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  assign any_elig = |elig;
  assign req_held = |(req & grant);

  // Search starts at the rr pointer (or at 0 for fixed priority) and wraps
  always_comb begin
    arb_base  = rr_en ? rr_ptr_q : '0;
    arb_cand  = '0;
    arb_idx   = '0;
    arb_found = 1'b0;
    for (int k = 0; k < int'(N_IF); k++) begin
      arb_cand = IDX_W'((int'(arb_base) + k) % int'(N_IF));
      if (!arb_found && elig[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
  end

  always_comb begin
    arb_mode = '0;
    arb_feat = '0;
    for (int i = 0; i < int'(N_IF); i++) begin
      if (arb_idx == IDX_W'(i)) begin
        arb_mode = mode[i*CODE_W +: CODE_W];
        arb_feat = feat[i*FEAT_W +: FEAT_W];
      end
    end
  end

  // Next-state and registered-output values
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    rr_ptr_d = rr_ptr_q;
    feat_d   = feat_q;
    step_d   = step_q;
    tick_d   = tick_q;
    grant_d  = grant;
    busy_d   = busy;
    done_d   = 1'b0;
    led_d    = led;
    seg_d    = seg;

    unique case (state_q)
      IDLE: begin
        if (any_elig) begin
          state_d = RUN;
          win_d   = arb_idx;
          feat_d  = arb_feat;
          step_d  = '0;
          tick_d  = '0;
          grant_d = N_IF'(1) << arb_idx;
          busy_d  = 1'b1;
          led_d   = LED_W'(1);
          seg_d   = digit(arb_mode[2:0]);
        end
      end

      RUN: begin
        // Withdrawal of the granted request acts like an abort and beats completion
        if (abort || !req_held) begin
          state_d = IDLE;
          step_d  = '0;
          tick_d  = '0;
          grant_d = '0;
          busy_d  = 1'b0;
          led_d   = '0;
          seg_d   = '0;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (step_q < feat_q - FEAT_W'(1)) begin
            step_d = step_q + FEAT_W'(1);
            led_d  = LED_W'(1) << (step_q + FEAT_W'(1));
          end else begin
            state_d  = DONE;
            done_d   = 1'b1;
            step_d   = '0;
            grant_d  = '0;
            busy_d   = 1'b0;
            led_d    = '0;
            seg_d    = '0;
            rr_ptr_d = (win_q == IDX_LAST) ? '0 : win_q + IDX_W'(1);
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      win_q    <= '0;
      rr_ptr_q <= '0;
      feat_q   <= '0;
      step_q   <= '0;
      tick_q   <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      conflict <= 1'b0;
      done     <= 1'b0;
      led      <= '0;
      seg      <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      rr_ptr_q <= rr_ptr_d;
      feat_q   <= feat_d;
      step_q   <= step_d;
      tick_q   <= tick_d;
      grant    <= grant_d;
      busy     <= busy_d;
      conflict <= conflict_d;
      done     <= done_d;
      led      <= led_d;
      seg      <= seg_d;
    end
  end

endmodule
